// File: rtl/marquee_pkg.sv
// Shared character-code and 14-segment glyph definitions for the marquee buffer and display stage.
// Segment bit order: a b c d e f g1 g2 h j k l m n (bit 13 down to bit 0).
package marquee_pkg;

    localparam int DIGITS = 12;
    localparam int CHAR_W = 6;
    localparam int SEG_W  = 14;

    localparam logic [CHAR_W-1:0] CH_SPACE = 6'd0;
    localparam logic [CHAR_W-1:0] CH_A = 6'd1,  CH_B = 6'd2,  CH_C = 6'd3,  CH_D = 6'd4,  CH_E = 6'd5;
    localparam logic [CHAR_W-1:0] CH_F = 6'd6,  CH_G = 6'd7,  CH_H = 6'd8,  CH_I = 6'd9,  CH_J = 6'd10;
    localparam logic [CHAR_W-1:0] CH_K = 6'd11, CH_L = 6'd12, CH_M = 6'd13, CH_N = 6'd14, CH_O = 6'd15;
    localparam logic [CHAR_W-1:0] CH_P = 6'd16, CH_Q = 6'd17, CH_R = 6'd18, CH_S = 6'd19, CH_T = 6'd20;
    localparam logic [CHAR_W-1:0] CH_U = 6'd21, CH_V = 6'd22, CH_W = 6'd23, CH_X = 6'd24, CH_Y = 6'd25;
    localparam logic [CHAR_W-1:0] CH_Z = 6'd26;
    localparam logic [CHAR_W-1:0] CH_0 = 6'd27, CH_1 = 6'd28, CH_2 = 6'd29, CH_3 = 6'd30, CH_4 = 6'd31;
    localparam logic [CHAR_W-1:0] CH_5 = 6'd32, CH_6 = 6'd33, CH_7 = 6'd34, CH_8 = 6'd35, CH_9 = 6'd36;

    localparam logic [SEG_W-1:0] GL_BLANK = 14'b00000000_000000;
    localparam logic [SEG_W-1:0] GL_A = 14'b11101111_000000, GL_B = 14'b11110001_010010;
    localparam logic [SEG_W-1:0] GL_C = 14'b10011100_000000, GL_D = 14'b11110000_010010;
    localparam logic [SEG_W-1:0] GL_E = 14'b10011110_000000, GL_F = 14'b10001110_000000;
    localparam logic [SEG_W-1:0] GL_G = 14'b10111101_000000, GL_H = 14'b01101111_000000;
    localparam logic [SEG_W-1:0] GL_I = 14'b10010000_010010, GL_J = 14'b01111000_000000;
    localparam logic [SEG_W-1:0] GL_K = 14'b00001110_001100, GL_L = 14'b00011100_000000;
    localparam logic [SEG_W-1:0] GL_M = 14'b01101100_101000, GL_N = 14'b01101100_100100;
    localparam logic [SEG_W-1:0] GL_O = 14'b11111100_000000, GL_P = 14'b11001111_000000;
    localparam logic [SEG_W-1:0] GL_Q = 14'b11111100_000100, GL_R = 14'b11001111_000100;
    localparam logic [SEG_W-1:0] GL_S = 14'b10110111_000000, GL_T = 14'b10000000_010010;
    localparam logic [SEG_W-1:0] GL_U = 14'b01111100_000000, GL_V = 14'b00001100_001001;
    localparam logic [SEG_W-1:0] GL_W = 14'b01101100_000101, GL_X = 14'b00000000_101101;
    localparam logic [SEG_W-1:0] GL_Y = 14'b00000000_101010, GL_Z = 14'b10010000_001001;
    localparam logic [SEG_W-1:0] GL_0 = 14'b11111100_001001, GL_1 = 14'b01100000_001000;
    localparam logic [SEG_W-1:0] GL_2 = 14'b11011011_000000, GL_3 = 14'b11110001_000000;
    localparam logic [SEG_W-1:0] GL_4 = 14'b01100111_000000, GL_5 = 14'b10110111_000000;
    localparam logic [SEG_W-1:0] GL_6 = 14'b10111111_000000, GL_7 = 14'b11100000_000000;
    localparam logic [SEG_W-1:0] GL_8 = 14'b11111111_000000, GL_9 = 14'b11110111_000000;

endpackage

// File: rtl/glyph_rom14.sv
// Combinational character-code to 14-segment pattern lookup; unknown codes map to blank.
// Zero latency, no flow control.
module glyph_rom14
    import marquee_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [SEG_W-1:0]  seg
);

    always_comb begin
        seg = GL_BLANK;
        case (code)
            CH_A: seg = GL_A;  CH_B: seg = GL_B;  CH_C: seg = GL_C;  CH_D: seg = GL_D;
            CH_E: seg = GL_E;  CH_F: seg = GL_F;  CH_G: seg = GL_G;  CH_H: seg = GL_H;
            CH_I: seg = GL_I;  CH_J: seg = GL_J;  CH_K: seg = GL_K;  CH_L: seg = GL_L;
            CH_M: seg = GL_M;  CH_N: seg = GL_N;  CH_O: seg = GL_O;  CH_P: seg = GL_P;
            CH_Q: seg = GL_Q;  CH_R: seg = GL_R;  CH_S: seg = GL_S;  CH_T: seg = GL_T;
            CH_U: seg = GL_U;  CH_V: seg = GL_V;  CH_W: seg = GL_W;  CH_X: seg = GL_X;
            CH_Y: seg = GL_Y;  CH_Z: seg = GL_Z;
            CH_0: seg = GL_0;  CH_1: seg = GL_1;  CH_2: seg = GL_2;  CH_3: seg = GL_3;
            CH_4: seg = GL_4;  CH_5: seg = GL_5;  CH_6: seg = GL_6;  CH_7: seg = GL_7;
            CH_8: seg = GL_8;  CH_9: seg = GL_9;
            default: seg = GL_BLANK;
        endcase
    end

endmodule

// File: rtl/marquee_buffer.sv
// Message RAM with a scrolling 12-digit window; returns the glyph for a requested digit.
// Read latency 2 cycles, one request per cycle, no backpressure.
module marquee_buffer
    import marquee_pkg::*;
#(
    parameter int MSG_DEPTH = 32,
    parameter int DIV_W     = 24
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [CHAR_W-1:0]            wr_data,
    input  logic                         len_wr,
    input  logic [$clog2(MSG_DEPTH):0]   len_data,
    input  logic [DIV_W-1:0]             scroll_div,
    input  logic                         scroll_en,
    input  logic                         rd_req,
    input  logic [3:0]                   rd_digit,
    output logic [SEG_W-1:0]             seg_out,
    output logic                         seg_valid,
    output logic                         wrap
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;

    logic [CHAR_W-1:0] mem [MSG_DEPTH];

    logic [LW-1:0]    len;
    logic [AW-1:0]    offset;
    logic [DIV_W-1:0] presc;

    logic [LW-1:0]    len_clip;
    logic             scrolling;
    logic             at_end;

    always_comb begin
        len_clip  = (len_data > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : len_data;
        scrolling = (len > LW'(DIGITS));
        at_end    = (LW'(offset) == (len - LW'(1)));
    end

    // len_wr wins over a scroll step in the same cycle, suppressing its wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            len    <= '0;
            offset <= '0;
            presc  <= '0;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (len_wr) begin
                len    <= len_clip;
                offset <= '0;
                presc  <= '0;
            end else if (!scrolling) begin
                offset <= '0;
                presc  <= '0;
            end else if (scroll_en) begin
                if (presc == scroll_div) begin
                    presc <= '0;
                    if (at_end) begin
                        offset <= '0;
                        wrap   <= 1'b1;
                    end else begin
                        offset <= offset + AW'(1);
                    end
                end else begin
                    presc <= presc + DIV_W'(1);
                end
            end
        end
    end

    // When not scrolling, offset is 0 so pos == digit and out-of-range digits are blanked.
    logic [LW-1:0] pos;
    logic [LW-1:0] pos_wrapped;
    logic [AW-1:0] rd_addr;
    logic          rd_blank;

    always_comb begin
        pos         = LW'(offset) + LW'(rd_digit);
        pos_wrapped = (pos >= len) ? (pos - len) : pos;
        rd_addr     = pos_wrapped[AW-1:0];
        rd_blank    = (rd_digit >= 4'(DIGITS)) || (LW'(rd_digit) >= len);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read samples the RAM before this cycle's write lands (read-first).
    logic              s1_vld;
    logic              s1_blank;
    logic [CHAR_W-1:0] s1_code;
    logic [SEG_W-1:0]  glyph;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= rd_req;
        end
        s1_blank <= rd_blank;
        s1_code  <= mem[rd_addr];
    end

    glyph_rom14 u_rom (
        .code (s1_code),
        .seg  (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out   <= '0;
            seg_valid <= 1'b0;
        end else begin
            seg_valid <= s1_vld;
            if (s1_vld) begin
                seg_out <= s1_blank ? GL_BLANK : glyph;
            end
        end
    end

endmodule

// File: tb/tb_marquee_buffer.sv
// Randomized bench for marquee_buffer against a behavioural message/scroll model.
module tb_marquee_buffer;

    logic        clk = 1'b0;
    logic        rst, wr_en, len_wr, scroll_en, rd_req;
    logic [4:0]  wr_addr;
    logic [5:0]  wr_data, len_data;
    logic [23:0] scroll_div;
    logic [3:0]  rd_digit;
    logic [13:0] seg_out;
    logic        seg_valid, wrap;

    always #5 clk = ~clk;

    marquee_buffer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_wr(len_wr), .len_data(len_data), .scroll_div(scroll_div), .scroll_en(scroll_en),
        .rd_req(rd_req), .rd_digit(rd_digit), .seg_out(seg_out), .seg_valid(seg_valid), .wrap(wrap)
    );

    // Codes 1..36: A..Z then 0..9.
    localparam logic [13:0] FONT [36] = '{
        14'b11101111000000, 14'b11110001010010, 14'b10011100000000, 14'b11110000010010,
        14'b10011110000000, 14'b10001110000000, 14'b10111101000000, 14'b01101111000000,
        14'b10010000010010, 14'b01111000000000, 14'b00001110001100, 14'b00011100000000,
        14'b01101100101000, 14'b01101100100100, 14'b11111100000000, 14'b11001111000000,
        14'b11111100000100, 14'b11001111000100, 14'b10110111000000, 14'b10000000010010,
        14'b01111100000000, 14'b00001100001001, 14'b01101100000101, 14'b00000000101101,
        14'b00000000101010, 14'b10010000001001, 14'b11111100001001, 14'b01100000001000,
        14'b11011011000000, 14'b11110001000000, 14'b01100111000000, 14'b10110111000000,
        14'b10111111000000, 14'b11100000000000, 14'b11111111000000, 14'b11110111000000
    };

    int tests = 0;
    int fails = 0;

    int          m_len, m_off, m_presc;
    logic [5:0]  m_mem [32];
    logic        p1_vld, exp_vld, exp_wrap;
    logic [13:0] p1_seg, exp_seg;

    function automatic logic [13:0] glyph_of(int code);
        if (code >= 1 && code <= 36) return FONT[code-1];
        return 14'd0;
    endfunction

    function automatic logic [13:0] model_read(int d);
        if (d >= 12 || m_len == 0) return 14'd0;
        if (m_len <= 12) return (d < m_len) ? glyph_of(int'(m_mem[d])) : 14'd0;
        return glyph_of(int'(m_mem[(m_off + d) % m_len]));
    endfunction

    // Advance one clock: predict the message state and the 2-deep read pipe, then step.
    task automatic tick();
        logic [13:0] rv;
        logic        rq, nw;
        int          nl, no, np;
        rq = rd_req;
        rv = model_read(int'(rd_digit));
        nl = m_len; no = m_off; np = m_presc; nw = 1'b0;
        if (rst) begin
            nl = 0; no = 0; np = 0;
        end else if (len_wr) begin
            nl = (int'(len_data) > 32) ? 32 : int'(len_data); no = 0; np = 0;
        end else if (m_len <= 12) begin
            no = 0; np = 0;
        end else if (scroll_en) begin
            if (m_presc == int'(scroll_div)) begin
                np = 0; no = (m_off + 1) % m_len; nw = (no == 0);
            end else begin
                np = (m_presc + 1) % (1 << 24);
            end
        end
        @(posedge clk);
        if (wr_en) m_mem[wr_addr] = wr_data;
        if (rst) begin
            p1_vld = 1'b0; exp_vld = 1'b0; exp_seg = 14'd0;
        end else begin
            exp_vld = p1_vld;
            if (p1_vld) exp_seg = p1_seg;
            p1_vld = rq; p1_seg = rv;
        end
        m_len = nl; m_off = no; m_presc = np; exp_wrap = nw;
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; len_wr = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_reset();
        int nvld = 0;
        rst = 1'b1; tick(); tick();
        tests++; if (seg_out !== 14'd0) begin fails++; $display("FAIL reset_seg got %b want 0", seg_out); end
        tests++; if (seg_valid !== 1'b0) begin fails++; $display("FAIL reset_vld got %b want 0", seg_valid); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b want 0", wrap); end
        rst = 1'b0;
        for (int d = 0; d < 14; d++) begin
            rd_req = (d < 12); rd_digit = 4'(d);
            tick();
            if (seg_valid === 1'b1) nvld++;
            tests++;
            if (seg_valid !== exp_vld || seg_out !== exp_seg) begin
                fails++; $display("FAIL reset_read d=%0d got %b/%b want %b/%b", d, seg_valid, seg_out, exp_vld, exp_seg);
            end
        end
        tests++; if (nvld != 12) begin fails++; $display("FAIL reset_read_count got %0d want 12", nvld); end
        idle();
    endtask

    task automatic test_static();
        logic [5:0]  codes [6] = '{6'd1, 6'd12, 6'd5, 6'd13, 6'd1, 6'd14};
        logic [13:0] got [12];
        int k;
        scroll_en = 1'b1; scroll_div = 24'd0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = codes[i]; tick();
        end
        wr_en = 1'b0; len_wr = 1'b1; len_data = 6'd6; tick(); len_wr = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            k = 0;
            for (int i = 0; i < 12; i++) got[i] = 14'h3fff;
            for (int d = 0; d < 14; d++) begin
                rd_req = (d < 12); rd_digit = 4'(d);
                tick();
                if (seg_valid === 1'b1 && k < 12) begin got[k] = seg_out; k++; end
                tests++;
                if (seg_valid !== exp_vld || seg_out !== exp_seg || wrap !== 1'b0) begin
                    fails++; $display("FAIL static_read p=%0d d=%0d got %b/%b/%b want %b/%b/0", pass, d, seg_valid, seg_out, wrap, exp_vld, exp_seg);
                end
            end
            tests++; if (got[0] !== 14'b11101111000000) begin fails++; $display("FAIL static_A p=%0d got %b want 11101111000000", pass, got[0]); end
            tests++; if (got[5] !== 14'b01101100100100) begin fails++; $display("FAIL static_N got %b want 01101100100100", got[5]); end
            tests++; if (got[6] !== 14'd0) begin fails++; $display("FAIL static_blank got %b want 0", got[6]); end
            tests++; if (got[3] !== 14'b01101100101000) begin fails++; $display("FAIL static_M got %b want 01101100101000", got[3]); end
            rd_req = 1'b0;
            for (int i = 0; i < 20; i++) tick();
        end
        idle();
    endtask

    task automatic test_scroll();
        int wraps = 0;
        scroll_en = 1'b0;
        for (int i = 0; i < 14; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 6'($urandom_range(1, 36)); tick();
        end
        wr_en = 1'b0; len_wr = 1'b1; len_data = 6'd14; scroll_div = 24'd3; scroll_en = 1'b1;
        tick(); len_wr = 1'b0;
        for (int c = 0; c < 56; c++) begin
            rd_req = 1'($urandom_range(0, 1)); rd_digit = 4'($urandom_range(0, 11));
            if (m_off == 5) begin rd_req = 1'b1; rd_digit = 4'd11; end
            tick();
            if (wrap === 1'b1) wraps++;
            tests++;
            if (seg_valid !== exp_vld || seg_out !== exp_seg || wrap !== exp_wrap) begin
                fails++; $display("FAIL scroll c=%0d got %b/%b/%b want %b/%b/%b", c, seg_valid, seg_out, wrap, exp_vld, exp_seg, exp_wrap);
            end
        end
        tests++; if (wraps != 1) begin fails++; $display("FAIL scroll_wrap_count got %0d want 1", wraps); end
        rd_req = 1'b1; rd_digit = 4'd0; tick(); rd_req = 1'b0; tick();
        tests++;
        if (seg_valid !== 1'b1 || seg_out !== glyph_of(int'(m_mem[0]))) begin
            fails++; $display("FAIL scroll_home got %b/%b want 1/%b", seg_valid, seg_out, glyph_of(int'(m_mem[0])));
        end
        idle();
    endtask

    task automatic test_len_collision();
        int guard = 0;
        while (!(m_off == 13 && m_presc == 3) && guard < 80) begin tick(); guard++; end
        tests++; if (guard >= 80) begin fails++; $display("FAIL collide_setup got timeout want step at offset 13"); end
        len_wr = 1'b1; len_data = 6'd14; tick(); len_wr = 1'b0;
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL collide_wrap got %b want 0", wrap); end
        rd_req = 1'b1; rd_digit = 4'd0; tick(); rd_req = 1'b0; tick();
        tests++;
        if (seg_valid !== 1'b1 || seg_out !== glyph_of(int'(m_mem[0])) || seg_out !== exp_seg) begin
            fails++; $display("FAIL collide_offset got %b/%b want 1/%b", seg_valid, seg_out, glyph_of(int'(m_mem[0])));
        end
        idle();
    endtask

    task automatic test_clip();
        int wraps = 0;
        int k = 0;
        logic [13:0] got [12];
        scroll_en = 1'b0;
        for (int i = 14; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 6'($urandom_range(1, 36)); tick();
        end
        wr_en = 1'b0; len_wr = 1'b1; len_data = 6'd40; tick(); len_wr = 1'b0;
        for (int d = 0; d < 14; d++) begin
            rd_req = (d < 12); rd_digit = 4'(d); tick();
            if (seg_valid === 1'b1 && k < 12) begin got[k] = seg_out; k++; end
        end
        tests++; if (got[9] !== glyph_of(int'(m_mem[9]))) begin fails++; $display("FAIL clip_digit9 got %b want %b", got[9], glyph_of(int'(m_mem[9]))); end
        scroll_en = 1'b1; scroll_div = 24'd0;
        for (int c = 0; c < 70; c++) begin
            rd_req = 1'($urandom_range(0, 1)); rd_digit = 4'($urandom_range(0, 15));
            tick();
            if (wrap === 1'b1) wraps++;
            tests++;
            if (seg_valid !== exp_vld || seg_out !== exp_seg || wrap !== exp_wrap) begin
                fails++; $display("FAIL clip_scroll c=%0d got %b/%b/%b want %b/%b/%b", c, seg_valid, seg_out, wrap, exp_vld, exp_seg, exp_wrap);
            end
        end
        tests++; if (wraps != 2) begin fails++; $display("FAIL clip_wrap_count got %0d want 2", wraps); end
        idle();
    endtask

    task automatic test_read_first();
        logic [13:0] got [4];
        scroll_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 6'd1; len_wr = 1'b1; len_data = 6'd6; tick();
        idle(); tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 6'd26; rd_req = 1'b1; rd_digit = 4'd3;
        for (int c = 0; c < 4; c++) begin
            tick();
            got[c] = seg_out;
            wr_en = 1'b0; rd_req = (c == 0);
            tests++;
            if (seg_valid !== exp_vld || seg_out !== exp_seg) begin
                fails++; $display("FAIL rf_pipe c=%0d got %b/%b want %b/%b", c, seg_valid, seg_out, exp_vld, exp_seg);
            end
        end
        tests++; if (got[1] !== 14'b11101111000000) begin fails++; $display("FAIL rf_old got %b want 11101111000000", got[1]); end
        tests++; if (got[2] !== 14'b10010000001001) begin fails++; $display("FAIL rf_new got %b want 10010000001001", got[2]); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            rd_req = 1'b1; rd_digit = 4'($urandom_range(0, 11)); rst = (i == 5);
            tick();
            tests++;
            if (seg_valid !== exp_vld || seg_out !== exp_seg) begin
                fails++; $display("FAIL b2b i=%0d got %b/%b want %b/%b", i, seg_valid, seg_out, exp_vld, exp_seg);
            end
            if (i == 5 || i == 6) begin
                tests++; if (seg_valid !== 1'b0) begin fails++; $display("FAIL b2b_flush i=%0d got %b want 0", i, seg_valid); end
            end
            if (i == 4 || i == 7) begin
                tests++; if (seg_valid !== 1'b1) begin fails++; $display("FAIL b2b_resume i=%0d got %b want 1", i, seg_valid); end
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) scroll_div = 24'($urandom_range(0, 3));
            rst       = ($urandom_range(0, 299) == 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = 6'($urandom_range(0, 63));
            len_wr    = ($urandom_range(0, 49) == 0);
            len_data  = 6'($urandom_range(0, 40));
            scroll_en = ($urandom_range(0, 7) != 0);
            rd_req    = ($urandom_range(0, 3) != 0);
            rd_digit  = 4'($urandom_range(0, 15));
            tick();
            tests++;
            if (seg_valid !== exp_vld || seg_out !== exp_seg || wrap !== exp_wrap) begin
                fails++; $display("FAIL random c=%0d got %b/%b/%b want %b/%b/%b", c, seg_valid, seg_out, wrap, exp_vld, exp_seg, exp_wrap);
            end
        end
        idle();
    endtask

    initial begin
        m_len = 0; m_off = 0; m_presc = 0;
        p1_vld = 1'b0; exp_vld = 1'b0; exp_wrap = 1'b0; p1_seg = '0; exp_seg = '0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len_wr = 1'b0; len_data = '0;
        scroll_div = '0; scroll_en = 1'b0; rd_req = 1'b0; rd_digit = '0;
        test_reset();
        test_static();
        test_scroll();
        test_len_collision();
        test_clip();
        test_read_first();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
